// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcode constants,
// instruction format and error code enumerations, and the opcode-to-format decode.
package instr_encoder_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_OPCODE = 2'd3
    } err_e;

    function automatic fmt_e decode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_OP:                     f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            OP_JAL:                    f = FMT_J;
            default:                   f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_imm_scatter.sv
// Places a 32-bit immediate into its RV32I bit positions for a given format and
// flags immediates that are out of range or misaligned for that format.
module instr_encoder_imm_scatter
    import instr_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    input  logic [6:0]  funct7,
    input  logic        is_shift,
    output logic [31:0] placed,
    output logic        range_err,
    output logic        align_err
);

    logic signed [31:0] simm_s;
    assign simm_s = imm;

    // Scatter and range/alignment check, one arm per format.
    always_comb begin
        placed    = 32'h0000_0000;
        range_err = 1'b0;
        align_err = 1'b0;
        case (fmt)
            FMT_R: begin
                placed = {funct7, 25'b0};
            end
            FMT_I: begin
                if (is_shift) begin
                    // Shift amount is 5 bits; the upper slice carries funct7.
                    placed    = {funct7, imm[4:0], 20'b0};
                    range_err = |imm[31:5];
                end else begin
                    placed    = {imm[11:0], 20'b0};
                    range_err = (simm_s > 32'sd2047) || (simm_s < -32'sd2048);
                end
            end
            FMT_S: begin
                placed    = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                range_err = (simm_s > 32'sd2047) || (simm_s < -32'sd2048);
            end
            FMT_B: begin
                placed    = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                range_err = (simm_s > 32'sd4094) || (simm_s < -32'sd4096);
                align_err = imm[0];
            end
            FMT_U: begin
                placed    = {imm[31:12], 12'b0};
                range_err = |imm[11:0];
            end
            FMT_J: begin
                placed    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                range_err = (simm_s > 32'sd1048574) || (simm_s < -32'sd1048576);
                align_err = imm[0];
            end
            default: begin
                placed    = 32'h0000_0000;
                range_err = 1'b0;
                align_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded RV32I fields into instruction words and streams them into
// instruction memory through a one-entry, back-pressured write register.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W              = 12,
    parameter int unsigned RESET_ADDR = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              err_clr,
    output logic              wrapped,
    output logic [15:0]       instr_count
);

    localparam logic [ADDR_W-1:0] ADDR_STEP  = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] ADDR_INIT  = ADDR_W'(RESET_ADDR) & ALIGN_MASK;

    fmt_e              fmt_s;
    logic              is_shift_s;
    logic [31:0]       placed_s;
    logic              range_err_s;
    logic              align_err_s;
    logic [31:0]       fields_s;
    logic [31:0]       word_s;
    logic              bad_s;
    err_e              code_s;
    logic              accept_s;
    logic              done_s;
    logic              stall_s;
    logic [ADDR_W-1:0] load_addr_s;

    logic              imem_we_r;
    logic [31:0]       imem_wdata_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wrapped_r;
    logic              load_pend_r;
    logic [ADDR_W-1:0] load_val_r;
    logic              err_r;
    err_e              err_code_r;
    logic [15:0]       count_r;

    assign fmt_s       = decode_fmt(in_opcode);
    assign is_shift_s  = (in_opcode == OP_IMM) &&
                         ((in_funct3 == F3_SLL) || (in_funct3 == F3_SRX));
    assign stall_s     = imem_we_r && !imem_ready;
    assign done_s      = imem_we_r && imem_ready;
    assign accept_s    = in_valid && in_ready;
    assign load_addr_s = addr_value & ALIGN_MASK;

    instr_encoder_imm_scatter u_scatter (
        .fmt       (fmt_s),
        .imm       (in_imm),
        .funct7    (in_funct7),
        .is_shift  (is_shift_s),
        .placed    (placed_s),
        .range_err (range_err_s),
        .align_err (align_err_s)
    );

    // Register/funct fields present in each format.
    always_comb begin
        fields_s = 32'h0000_0000;
        case (fmt_s)
            FMT_R:        fields_s = {7'b0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I:        fields_s = {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S, FMT_B: fields_s = {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
            FMT_U, FMT_J: fields_s = {20'b0, in_rd, in_opcode};
            default:      fields_s = 32'h0000_0000;
        endcase
    end

    assign word_s = placed_s | fields_s;

    // Error classification; range is reported ahead of alignment.
    always_comb begin
        bad_s  = 1'b0;
        code_s = ERR_NONE;
        if (fmt_s == FMT_BAD) begin
            bad_s  = 1'b1;
            code_s = ERR_OPCODE;
        end else if (range_err_s) begin
            bad_s  = 1'b1;
            code_s = ERR_RANGE;
        end else if (align_err_s) begin
            bad_s  = 1'b1;
            code_s = ERR_ALIGN;
        end else begin
            bad_s  = 1'b0;
            code_s = ERR_NONE;
        end
    end

    // One-entry write register toward instruction memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_r    <= 1'b0;
            imem_wdata_r <= 32'h0000_0000;
        end else if (accept_s && !bad_s) begin
            imem_we_r    <= 1'b1;
            imem_wdata_r <= word_s;
        end else if (done_s) begin
            imem_we_r    <= 1'b0;
        end else begin
            imem_we_r    <= imem_we_r;
        end
    end

    // Write address: loads are held back while a write is stalled so the
    // pending word keeps its address, and a load beats the post-write increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r      <= ADDR_INIT;
            wrapped_r   <= 1'b0;
            load_pend_r <= 1'b0;
            load_val_r  <= ADDR_INIT;
        end else if (stall_s) begin
            if (addr_load) begin
                load_pend_r <= 1'b1;
                load_val_r  <= load_addr_s;
            end
        end else if (addr_load) begin
            addr_r      <= load_addr_s;
            wrapped_r   <= 1'b0;
            load_pend_r <= 1'b0;
        end else if (load_pend_r) begin
            addr_r      <= load_val_r;
            wrapped_r   <= 1'b0;
            load_pend_r <= 1'b0;
        end else if (done_s) begin
            addr_r <= addr_r + ADDR_STEP;
            if (&addr_r[ADDR_W-1:2]) begin
                wrapped_r <= 1'b1;
            end
        end
    end

    // Sticky error; a new error in the clear cycle wins and is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else if (accept_s && bad_s) begin
            err_r <= 1'b1;
            if (!err_r || err_clr) begin
                err_code_r <= code_s;
            end
        end else if (err_clr) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end
    end

    // Saturating count of completed writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'h0000;
        end else if (done_s && (count_r != 16'hFFFF)) begin
            count_r <= count_r + 16'h0001;
        end
    end

    assign in_ready    = !imem_we_r || imem_ready;
    assign imem_we     = imem_we_r;
    assign imem_wdata  = imem_wdata_r;
    assign imem_addr   = addr_r;
    assign err         = err_r;
    assign err_code    = err_code_r;
    assign wrapped     = wrapped_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected writes, a
// negedge monitor checks every completed memory write against the queue.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        addr_load;
    logic [11:0] addr_value;
    logic        imem_we;
    logic        imem_ready;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr;
    logic        wrapped;
    logic [15:0] instr_count;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_wr = 0;
    int          prev_wr = 0;
    int          n_good = 0;
    logic [11:0] ea = 12'h000;
    logic [11:0] wa;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder #(.ADDR_W(12), .RESET_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_load(addr_load), .addr_value(addr_value), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .err(err), .err_code(err_code), .err_clr(err_clr), .wrapped(wrapped),
        .instr_count(instr_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, no write expected",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {20'h0, imem_addr}, {20'h0, e.a});
                check("wr_data", imem_wdata, e.d);
            end
            prev_wr = last_wr;
            last_wr = cyc;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input bit good, input logic [31:0] data);
        int n;
        n = 0;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid  = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        if (good) begin
            exp_q.push_back({ea, data});
            ea = ea + 12'h004;
            n_good++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_addr(input logic [11:0] v);
        addr_load  = 1'b1;
        addr_value = v;
        tick();
        addr_load  = 1'b0;
        ea = v;
    endtask

    task automatic pulse_clr;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 7'h00; in_rd = 5'd0; in_rs1 = 5'd0;
        in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0;
        addr_load = 1'b0; addr_value = 12'h000; imem_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_we", {31'b0, imem_we}, 32'd0);
        check("rst_addr", {20'b0, imem_addr}, 32'h000);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        check("rst_wrapped", {31'b0, wrapped}, 32'd0);
        check("rst_count", {16'b0, instr_count}, 32'd0);
        tick();

        // addi x1,x0,5: visible one cycle after acceptance
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
        @(negedge clk);
        check("addi_we_next", {31'b0, imem_we}, 32'd1);
        tick();
        check("addi_count", {16'b0, instr_count}, 32'd1);

        // sw x2,-4(x1) then beq x0,x0,-8 back to back from address 0
        load_addr(12'h000);
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_AE23);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b1, 32'hFE00_0CE3);
        tick(); tick();
        check("no_bubble", last_wr - prev_wr, 32'd1);

        // jal / lui / lui with low bits set
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h0010_00EF);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b0, 32'h0);
        check("lui_bad_err", {31'b0, err}, 32'd1);
        check("lui_bad_code", {30'b0, err_code}, 32'd1);
        pulse_clr();
        check("clr_err", {31'b0, err}, 32'd0);
        check("clr_code", {30'b0, err_code}, 32'd0);

        // addi 2048 -> range; odd beq keeps the first code
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0);
        check("addi2048_code", {30'b0, err_code}, 32'd1);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0);
        check("first_code_kept", {30'b0, err_code}, 32'd1);
        pulse_clr();
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4095, 1'b0, 32'h0);
        check("beq4095_range_first", {30'b0, err_code}, 32'd1);
        pulse_clr();
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0);
        check("beq_odd_align", {30'b0, err_code}, 32'd2);
        // bad opcode together with err_clr: the new error is latched
        err_clr = 1'b1;
        send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
        err_clr = 1'b0;
        check("badop_err", {31'b0, err}, 32'd1);
        check("badop_code", {30'b0, err_code}, 32'd3);
        pulse_clr();

        // shifts: srai x1,x1,3 legal, slli by 32 out of range
        send(7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1, 32'h4030_D093);
        send(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'h00, 32'd32, 1'b0, 32'h0);
        check("shamt_range", {30'b0, err_code}, 32'd1);
        pulse_clr();

        // back-pressure for 3 cycles with a deferred address load
        tick();
        imem_ready = 1'b0;
        wa = ea;
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'h0010_0113);
        addr_load  = 1'b1;
        addr_value = 12'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_wdata", imem_wdata, 32'h0010_0113);
            check("stall_addr", {20'b0, imem_addr}, {20'b0, wa});
            tick();
            addr_load = 1'b0;
        end
        imem_ready = 1'b1;
        tick();
        @(negedge clk);
        check("release_we", {31'b0, imem_we}, 32'd0);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("deferred_load", {20'b0, imem_addr}, 32'h100);
        ea = 12'h100;
        tick();
        send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 32'h0070_0193);

        // wrap past the top address
        tick();
        load_addr(12'hFFC);
        send(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0213);
        send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0293);
        tick(); tick();
        check("wrapped_set", {31'b0, wrapped}, 32'd1);

        // addr_load coincident with a completing write
        send(7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b1, 32'hABCD_E337);
        addr_load  = 1'b1;
        addr_value = 12'h202;
        tick();
        addr_load = 1'b0;
        ea = 12'h200;
        check("load_clears_wrapped", {31'b0, wrapped}, 32'd0);
        send(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0000_0393);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_count", {16'b0, instr_count}, n_good);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
